// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with a registered one-hot grant that feeds a one-hot AND-OR selector.
// The grant is held until the owner acks or drops its request, then priority rotates past the owner.
module rr_arbiter_onehot #(
    parameter int in_val = 4,
    parameter int idx_w  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [in_val-1:0] req,
    input  logic              ack,
    output logic [in_val-1:0] grant,
    output logic              grant_valid,
    output logic [idx_w-1:0]  grant_idx
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [idx_w-1:0] last_idx = idx_w'(in_val - 1);

    state_t              state, state_nxt;
    logic [idx_w-1:0]    ptr, ptr_nxt;
    logic [idx_w-1:0]    idx_inc, base, win, idx_nxt;
    logic [in_val-1:0]   onehot, grant_nxt;
    logic                valid_nxt, rel;

    // Releasing owner becomes lowest priority: the search restarts one past it.
    always_comb begin
        idx_inc = (grant_idx == last_idx) ? '0 : grant_idx + 1'b1;
        rel     = ack | ~(|(grant & req));
        base    = (state == BUSY) ? idx_inc : ptr;
    end

    // Winner is the requester with the smallest rotational distance from base.
    always_comb begin
        int best;
        int d;
        best   = in_val;
        d      = 0;
        win    = base;
        onehot = '0;
        for (int j = 0; j < in_val; j++) begin
            if (req[j]) begin
                d = (j >= int'(base)) ? j - int'(base) : j + in_val - int'(base);
                if (d < best) begin
                    best = d;
                    win  = idx_w'(j);
                end
            end
        end
        for (int j = 0; j < in_val; j++) begin
            onehot[j] = (idx_w'(j) == win);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        idx_nxt   = grant_idx;
        valid_nxt = grant_valid;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = onehot;
                    idx_nxt   = win;
                    valid_nxt = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_nxt = idx_inc;
                    if (|req) begin
                        grant_nxt = onehot;
                        idx_nxt   = win;
                    end else begin
                        grant_nxt = '0;
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            grant_valid <= valid_nxt;
            grant_idx   <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Directed bench for rr_arbiter_onehot: reset, rotation, wrap, hold, withdraw, reset mid-grant,
// single-requester build, and a random phase with a one-hot invariant check.
module tb_rr_arbiter_onehot;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;

    logic [0:0] req1;
    logic       ack1;
    logic [0:0] grant1;
    logic       grant_valid1;
    logic [0:0] grant_idx1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_onehot #(.in_val(4), .idx_w(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    rr_arbiter_onehot #(.in_val(1), .idx_w(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .req         (req1),
        .ack         (ack1),
        .grant       (grant1),
        .grant_valid (grant_valid1),
        .grant_idx   (grant_idx1)
    );

    assert property (@(posedge clk) disable iff (rst) ($onehot0(grant) && (grant_valid == (|grant))))
        else begin
            n_errors++;
            $display("FAIL invariant: grant=%b grant_valid=%b", grant, grant_valid);
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] idx);
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_valid"}, 32'(grant_valid), 32'(|g));
        check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
    endtask

    initial begin
        logic [3:0] seq [4];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst  = 1'b1;
        req  = 4'b1111;
        ack  = 1'b0;
        req1 = 1'b0;
        ack1 = 1'b0;

        tick;
        tick;
        expect_grant("reset", 4'b0000, 2'd0);

        rst = 1'b0;
        tick;
        expect_grant("first", 4'b0001, 2'd0);

        // Full load, ack every second granted cycle.
        for (int k = 0; k < 4; k++) begin
            ack = 1'b0;
            tick;
            expect_grant("rot_hold", (k == 0) ? 4'b0001 : seq[k-1], 2'(k));
            ack = 1'b1;
            tick;
            ack = 1'b0;
            expect_grant("rot_next", seq[k], 2'((k + 1) % 4));
        end

        // Sparse requests with wrap.
        req = 4'b1000; ack = 1'b1;
        tick;
        expect_grant("to3", 4'b1000, 2'd3);
        req = 4'b0101; ack = 1'b1;
        tick;
        expect_grant("wrap", 4'b0001, 2'd0);
        tick;
        expect_grant("sparse2", 4'b0100, 2'd2);

        // Owner 2 holds while a lower index requests.
        ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            expect_grant("hold", 4'b0100, 2'd2);
        end

        // Withdraw paths.
        req = 4'b0010;
        tick;
        expect_grant("drop2", 4'b0010, 2'd1);
        req = 4'b0000;
        tick;
        expect_grant("withdraw", 4'b0000, 2'd1);
        ack = 1'b1;
        tick;
        expect_grant("idle_ack", 4'b0000, 2'd1);
        ack = 1'b0;
        req = 4'b0011;
        tick;
        expect_grant("ptr2", 4'b0001, 2'd0);

        // One-cycle grants back to back.
        ack = 1'b1;
        tick;
        expect_grant("min1", 4'b0010, 2'd1);
        tick;
        expect_grant("min2", 4'b0001, 2'd0);

        // Reset in the middle of a grant.
        req = 4'b1000;
        tick;
        expect_grant("pre_rst", 4'b1000, 2'd3);
        ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_grant("async_rst", 4'b0000, 2'd0);
        tick;
        rst = 1'b0;
        req = 4'b1111;
        expect_grant("rst_held", 4'b0000, 2'd0);
        tick;
        expect_grant("post_rst", 4'b0001, 2'd0);

        // Single requester: re-granted across acks.
        req1 = 1'b1;
        tick;
        check("n1_grant", 32'(grant1), 32'd1);
        ack1 = 1'b1;
        tick;
        check("n1_regrant", 32'(grant1), 32'd1);
        check("n1_valid", 32'(grant_valid1), 32'd1);
        check("n1_idx", 32'(grant_idx1), 32'd0);
        req1 = 1'b0;
        ack1 = 1'b0;
        tick;
        check("n1_idle", 32'(grant1), 32'd0);
        check("n1_idle_valid", 32'(grant_valid1), 32'd0);

        // Random stimulus with invariant checks.
        for (int k = 0; k < 300; k++) begin
            req = 4'($urandom);
            ack = 1'($urandom_range(0, 1));
            tick;
            check("rnd_onehot", 32'($onehot0(grant)), 32'd1);
            check("rnd_valid", 32'(grant_valid), 32'(|grant));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_onehot.md
# rr_arbiter_onehot

Round-robin arbiter producing the registered one-hot select vector that drives the AND-OR one-hot data selector directly downstream. It arbitrates among `in_val` requesters, holds a grant until the owner acknowledges completion or withdraws its request, then rotates priority. `grant` connects unmodified to the selector's `sel`, so the selector always sees a one-hot or all-zero vector.

## Interface
- `in_val`, default 4: number of requesters, ≥1; must match the downstream selector's `in_val`.
- `idx_w`, default 2: width of `grant_idx`; set to max(1, ceil(log2(in_val))).

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req`  input  in_val: request per requester; level-sensitive.
- `ack`  input  1: current owner finished; meaningful only while `grant_valid`=1.
- `grant`  output  in_val: registered one-hot grant / selector `sel`; all-zero when idle.
- `grant_valid`  output  1: high exactly when `grant` is non-zero.
- `grant_idx`  output  idx_w: binary index of the granted requester; holds the last value when idle.

## Operation
- State: 2-state FSM (IDLE, BUSY) plus priority pointer `ptr` (idx_w bits, range 0..in_val-1).
- Reset (async, immediate): `grant`=0, `grant_valid`=0, `grant_idx`=0, `ptr`=0, FSM=IDLE.
- Winner search: first set bit of `req` scanning `ptr`, `ptr`+1, …, in_val-1, 0, …, `ptr`-1, with wrap modulo in_val.
- IDLE: if `req`≠0, register winner w: `grant`=1<<w, `grant_idx`=w, `grant_valid`=1, go BUSY. Else stay IDLE, outputs unchanged.
- BUSY, release event = `ack`=1 OR `req[grant_idx]`=0:
  - No release: hold `grant`/`grant_idx` unchanged, regardless of other requests.
  - Release: `ptr` ← (`grant_idx`+1) mod in_val. Re-arbitrate in the same cycle using that new pointer against current `req`.
  - Re-arbitration, `req`≠0: grant the new winner next cycle, back-to-back with no idle gap; stay BUSY. The releasing requester is eligible only at lowest priority.
  - Re-arbitration, `req`=0: `grant`=0, `grant_valid`=0, go IDLE.
- `ack` while IDLE: ignored.
- Priority rotation (`ptr` update): only on release, never on grant.
- Invariant: `grant` has at most one bit set, and `grant_valid` = |`grant` at all times.
- in_val=1: `ptr` stays 0. Requester 0 is re-granted back-to-back while `req[0]`=1 across acks.

## Timing
- Grant latency: `req` first sampled high at edge n → `grant` valid after edge n (visible in cycle n+1). One cycle.
- Release latency: `ack`, or the owner's `req` drop, sampled at edge m → new grant or all-zero after edge m. No dead cycle between owners.
- Minimum grant length: 1 cycle, when `ack` is high in the first granted cycle.
- All outputs come straight from flops; no combinational path from `req`/`ack` to outputs.
- Reset mid-grant: `grant` clears asynchronously on `rst` assertion. First grant after deassertion uses `ptr`=0.

## Test plan
- Reset: assert `rst` with `req`=4'b1111 → `grant`=0, `grant_valid`=0, `grant_idx`=0 while asserted. After release, first grant is 4'b0001 one cycle later.
- Full-load rotation: `req`=4'b1111, `ack` pulsed every 2nd granted cycle → grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles between owners.
- Sparse requests with wrap: owner 3 acks while `req`=4'b0101 → next grant 0001 (wrap), then 0100 after the next ack.
- Hold vs. lower index: owner 2 granted, `req` adds bit 0, no `ack` for 5 cycles → `grant` stays 0100 all 5 cycles.
- Withdraw: owner 1 granted, `req[1]` drops without `ack` and `req`=0 → `grant`=0, `grant_valid`=0 next cycle, then a later request from 1 gets lowest priority (`ptr`=2).
- Reset mid-grant plus invariant checker: `rst` pulse while `grant`=1000 → outputs clear immediately. A concurrent assertion checks one-hot/zero `grant` and `grant_valid`==|`grant` on every cycle of random `req`/`ack` stimulus.
